// File: rtl/param_pkg.sv
// param_pkg: VC-4 geometry, POH row indices and shared types for vc4_poh_mapper.
`default_nettype none

package param_pkg;

  localparam int c4_Length  = 260;
  localparam int vc4_Length = 261;
  localparam int vc4_Width  = 9;

  localparam logic [3:0] POH_J1 = 4'd0;
  localparam logic [3:0] POH_B3 = 4'd1;
  localparam logic [3:0] POH_C2 = 4'd2;
  localparam logic [3:0] POH_G1 = 4'd3;
  localparam logic [3:0] POH_F2 = 4'd4;
  localparam logic [3:0] POH_H4 = 4'd5;
  localparam logic [3:0] POH_F3 = 4'd6;
  localparam logic [3:0] POH_K3 = 4'd7;
  localparam logic [3:0] POH_N1 = 4'd8;

  typedef logic [vc4_Width-1:0][7:0] poh_bytes_t;

  typedef enum logic [1:0] {
    ST_SYNC    = 2'd0,
    ST_POH     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/vc4_bip8.sv
// vc4_bip8: BIP-8 accumulator with latched per-frame result (built only with VC4_B3_BIP_EN).
`default_nettype none

`ifdef VC4_B3_BIP_EN
module vc4_bip8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_clr_res,
  input  logic       i_en,
  input  logic       i_latch,
  input  logic [7:0] i_data,
  output logic [7:0] o_b3
);

  logic [7:0] r_acc;
  logic [7:0] r_b3;

  assign o_b3 = r_b3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_b3  <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        // The last byte of the frame is folded into the result, not the next frame.
        if (i_latch) begin
          r_b3  <= r_acc ^ i_data;
          r_acc <= '0;
        end else begin
          r_acc <= r_acc ^ i_data;
        end
      end
      if (i_clr_res) begin
        r_b3 <= '0;
      end
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/vc4_poh_mapper.sv
// vc4_poh_mapper: inserts a POH column in front of a 9x260 C-4 stream to form a 9x261 VC-4.
// Macro VC4_B3_BIP_EN enables the BIP-8 (B3) computation; otherwise B3 is constant 8'h00.
`default_nettype none

module vc4_poh_mapper
  import param_pkg::*;
#(
  parameter logic [7:0] J1_BYTE  = 8'h01,
  parameter logic [7:0] C2_LABEL = 8'h12,
  parameter logic [7:0] G1_BYTE  = 8'h00,
  parameter logic [7:0] F2_BYTE  = 8'h00,
  parameter logic [7:0] H4_BYTE  = 8'h00,
  parameter logic [7:0] F3_BYTE  = 8'h00,
  parameter logic [7:0] K3_BYTE  = 8'h00,
  parameter logic [7:0] N1_BYTE  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       out_eof,
  input  logic       out_ready,
  output logic       sof_err
);

  state_t     r_state;
  logic [3:0] r_row;
  logic [8:0] r_col;
  logic       r_live;

  logic       w_adv;
  logic       w_first;
  logic       w_in_xfer;
  logic       w_sof_bad;
  logic       w_sof_miss;
  logic       w_pay_load;
  logic       w_last_col;
  logic       w_last_row;
  logic [7:0] w_b3;
  logic [7:0] w_load_data;
  poh_bytes_t w_poh;

  assign w_adv      = !out_valid | out_ready;
  assign w_first    = (r_row == POH_J1) && (r_col == 9'd1);
  assign w_last_col = (r_col == 9'(vc4_Length - 1));
  assign w_last_row = (r_row == POH_N1);

  // r_live keeps in_ready low while reset is asserted and on the first cycle after it.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      ST_SYNC:    in_ready = r_live & !in_sof;
      ST_PAYLOAD: in_ready = w_adv & (w_first | !in_sof);
      default:    in_ready = 1'b0;
    endcase
  end

  assign w_in_xfer  = in_valid & in_ready;
  assign w_sof_bad  = (r_state == ST_PAYLOAD) & in_valid & in_sof & !w_first;
  assign w_sof_miss = (r_state == ST_PAYLOAD) & w_in_xfer & w_first & !in_sof;
  assign w_pay_load = (r_state == ST_PAYLOAD) & w_in_xfer & !w_sof_miss;

  always_comb begin
    w_poh         = '0;
    w_poh[POH_J1] = J1_BYTE;
    w_poh[POH_B3] = w_b3;
    w_poh[POH_C2] = C2_LABEL;
    w_poh[POH_G1] = G1_BYTE;
    w_poh[POH_F2] = F2_BYTE;
    w_poh[POH_H4] = H4_BYTE;
    w_poh[POH_F3] = F3_BYTE;
    w_poh[POH_K3] = K3_BYTE;
    w_poh[POH_N1] = N1_BYTE;
  end

  assign w_load_data = (r_state == ST_POH) ? w_poh[r_row] : in_data;

`ifdef VC4_B3_BIP_EN
  logic w_load;
  assign w_load = ((r_state == ST_POH) & w_adv) | w_pay_load;

  vc4_bip8 u_bip8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_sof_bad | w_sof_miss),
    .i_clr_res (w_sof_bad),
    .i_en      (w_load),
    .i_latch   (w_pay_load & w_last_col & w_last_row),
    .i_data    (w_load_data),
    .o_b3      (w_b3)
  );
`else
  assign w_b3 = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_SYNC;
      r_row     <= '0;
      r_col     <= '0;
      r_live    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      sof_err   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      sof_err <= 1'b0;
      if (w_adv) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eof   <= 1'b0;
      end
      case (r_state)
        ST_SYNC: begin
          // The sof byte itself stays on the input; it is consumed at row 0 col 1.
          if (in_valid && in_sof) begin
            r_row   <= POH_J1;
            r_col   <= '0;
            r_state <= ST_POH;
          end
        end
        ST_POH: begin
          if (w_adv) begin
            out_data  <= w_load_data;
            out_valid <= 1'b1;
            out_sof   <= (r_row == POH_J1);
            r_col     <= 9'd1;
            r_state   <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (w_sof_bad) begin
            sof_err <= 1'b1;
            r_row   <= POH_J1;
            r_col   <= '0;
            r_state <= ST_POH;
          end else if (w_sof_miss) begin
            sof_err <= 1'b1;
            r_row   <= POH_J1;
            r_col   <= '0;
            r_state <= ST_SYNC;
          end else if (w_pay_load) begin
            out_data  <= w_load_data;
            out_valid <= 1'b1;
            out_eof   <= w_last_col & w_last_row;
            if (w_last_col) begin
              r_col   <= '0;
              r_row   <= w_last_row ? POH_J1 : r_row + 4'd1;
              r_state <= ST_POH;
            end else begin
              r_col <= r_col + 9'd1;
            end
          end
        end
        default: r_state <= ST_SYNC;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vc4_poh_mapper.sv
// tb_vc4_poh_mapper: directed checks of POH insertion, B3, backpressure, sof handling and reset.
`default_nettype none

module tb_vc4_poh_mapper;

  localparam int FRAME = 2349;
`ifdef VC4_B3_BIP_EN
  localparam logic [7:0] EXP_B3_AA = 8'h13;
`else
  localparam logic [7:0] EXP_B3_AA = 8'h00;
`endif

  typedef struct packed {logic [7:0] d; logic sof;} in_t;
  typedef struct packed {logic [7:0] d; logic sof; logic eof;} out_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_sof;
  logic       out_eof;
  logic       out_ready = 1'b1;
  logic       sof_err;

  in_t  src[$];
  out_t cap[$];
  int   checks = 0;
  int   errors = 0;
  int   n_consumed, n_sof_err, n_ready_viol;

  vc4_poh_mapper dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_ready (out_ready),
    .sof_err   (sof_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] poh(input int r, input logic [7:0] b3);
    case (r)
      0:       return 8'h01;
      1:       return b3;
      2:       return 8'h12;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] c4(input int pat, input int r, input int c);
    int v;
    v = (r * 260 + c) & 255;
    return (pat != 0) ? 8'hAA : v[7:0];
  endfunction

  // Pushes C-4 bytes rows 0..nrows-1 fully, then ncols bytes of row nrows.
  task automatic push_c4(input int pat, input int nrows, input int ncols);
    for (int r = 0; r < 9; r++)
      for (int c = 0; c < 260; c++)
        if (r < nrows || (r == nrows && c < ncols))
          src.push_back({c4(pat, r, c), (r == 0 && c == 0)});
  endtask

  task automatic cmp_frame(input string tag, input int base, input int pat, input logic [7:0] b3);
    int   bad;
    out_t e;
    bad = 0;
    for (int r = 0; r < 9; r++)
      for (int k = 0; k < 261; k++) begin
        e.d   = (k == 0) ? poh(r, b3) : c4(pat, r, k - 1);
        e.sof = (r == 0 && k == 0);
        e.eof = (r == 8 && k == 260);
        if (cap[base + r * 261 + k] !== e) bad++;
      end
    chk(tag, bad, 0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset outputs", {in_ready, out_valid, out_sof, out_eof, sof_err, out_data}, 0);
    rst_n = 1'b1;
    src.delete();
    cap.delete();
    n_consumed   = 0;
    n_sof_err    = 0;
    n_ready_viol = 0;
  endtask

  // Drives src and collects outputs until n_out bytes are captured or the cycle budget runs out.
  task automatic run(input int n_out, input bit rnd);
    int   cyc;
    bit   xin, xout;
    out_t od;
    cyc = 0;
    while (cap.size() < n_out && cyc < n_out * 4 + 200) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (src.size() > 0) begin
        in_valid = 1'b1;
        in_data  = src[0].d;
        in_sof   = src[0].sof;
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
      end
      #4;
      xin  = in_valid & in_ready;
      xout = out_valid & out_ready;
      if (out_valid && !out_ready && in_ready) n_ready_viol++;
      if (sof_err) n_sof_err++;
      od = {out_data, out_sof, out_eof};
      @(posedge clk);
      if (xin) begin
        void'(src.pop_front());
        n_consumed++;
      end
      if (xout) cap.push_back(od);
      cyc++;
    end
    chk("output count within budget", cap.size() >= n_out, 1);
    while (cap.size() < n_out) cap.push_back('x);
  endtask

  initial begin
    // Test 1: counting pattern, full throughput.
    do_reset();
    push_c4(0, 9, 0);
    run(FRAME, 1'b0);
    chk("t1 J1 with sof", cap[0], {8'h01, 1'b1, 1'b0});
    chk("t1 B3", cap[261].d, 8'h00);
    chk("t1 C2", cap[522].d, 8'h12);
    chk("t1 eof", {cap[2348].eof, cap[2347].eof}, 2'b10);
    cmp_frame("t1 frame", 0, 0, 8'h00);

    // Test 2: two back-to-back all-AA frames.
    do_reset();
    push_c4(1, 9, 0);
    push_c4(1, 9, 0);
    run(2 * FRAME, 1'b0);
    chk("t2 frame1 B3", cap[261].d, 8'h00);
    chk("t2 frame2 B3", cap[FRAME + 261].d, EXP_B3_AA);
    cmp_frame("t2 frame1", 0, 1, 8'h00);
    cmp_frame("t2 frame2", FRAME, 1, EXP_B3_AA);

    // Test 3: random backpressure.
    do_reset();
    push_c4(0, 9, 0);
    run(FRAME, 1'b1);
    cmp_frame("t3 frame", 0, 0, 8'h00);
    chk("t3 in_ready during stall", n_ready_viol, 0);
    chk("t3 consumed", n_consumed, 2340);

    // Test 4: garbage before sof is dropped.
    do_reset();
    for (int i = 0; i < 5; i++) src.push_back({8'(8'hE0 + i), 1'b0});
    push_c4(0, 9, 0);
    run(FRAME, 1'b0);
    chk("t4 first out J1", cap[0], {8'h01, 1'b1, 1'b0});
    chk("t4 consumed", n_consumed, 2345);
    cmp_frame("t4 frame", 0, 0, 8'h00);

    // Test 5: full frame, partial frame with sof at row 3 col 50, full frame.
    do_reset();
    push_c4(0, 9, 0);
    push_c4(1, 3, 49);
    push_c4(0, 9, 0);
    run(FRAME + 833 + FRAME, 1'b0);
    cmp_frame("t5 frame A", 0, 0, 8'h00);
    chk("t5 sof_err pulses", n_sof_err, 1);
    chk("t5 J1 after abort", cap[FRAME + 833], {8'h01, 1'b1, 1'b0});
    chk("t5 B3 forced zero", cap[FRAME + 833 + 261].d, 8'h00);
    chk("t5 partial last byte", cap[FRAME + 832], {8'hAA, 1'b0, 1'b0});
    cmp_frame("t5 frame C", FRAME + 833, 0, 8'h00);

    // Test 6: reset pulse in row 4, then resync.
    do_reset();
    push_c4(0, 9, 0);
    run(4 * 261 + 10, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    chk("t6 busy before reset", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6 outputs zero in reset", {in_ready, out_valid, out_sof, out_eof, sof_err, out_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    src.delete();
    cap.delete();
    n_consumed = 0;
    for (int i = 0; i < 5; i++) src.push_back({8'(8'h30 + i), 1'b0});
    push_c4(0, 9, 0);
    run(FRAME, 1'b0);
    chk("t6 consumed", n_consumed, 2345);
    cmp_frame("t6 frame", 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
